// File: rtl/cpu6_dmem_responder_pkg.sv
// Shared definitions for the cpu6 data-memory responder.
// Holds the MMIO window select bits, the MMIO register offsets, the
// register-select enum and the offset decoder used by the responder top.
package cpu6_dmem_responder_pkg;

  // Address bits that select the MMIO window against MMIO_BASE.
  localparam int CPU6_MMIO_SEL_HIGH = 31;
  localparam int CPU6_MMIO_SEL_LOW  = 28;

  // Word offsets inside the MMIO window (dataaddr[7:0]).
  localparam logic [7:0] CPU6_MMIO_MTIME_LO    = 8'h00;
  localparam logic [7:0] CPU6_MMIO_MTIME_HI    = 8'h04;
  localparam logic [7:0] CPU6_MMIO_MTIMECMP_LO = 8'h08;
  localparam logic [7:0] CPU6_MMIO_MTIMECMP_HI = 8'h0C;
  localparam logic [7:0] CPU6_MMIO_TXDATA      = 8'h10;
  localparam logic [7:0] CPU6_MMIO_STATUS      = 8'h14;

  // STATUS write bit that clears the sticky overflow flag.
  localparam int STATUS_CLR_OVF_BIT = 3;

  typedef enum logic [2:0] {
    MMIO_NONE        = 3'd0,
    MMIO_MTIME_LO    = 3'd1,
    MMIO_MTIME_HI    = 3'd2,
    MMIO_MTIMECMP_LO = 3'd3,
    MMIO_MTIMECMP_HI = 3'd4,
    MMIO_TXDATA      = 3'd5,
    MMIO_STATUS      = 3'd6
  } mmio_reg_e;

  // Map an MMIO byte offset to a register. The two low bits are ignored so
  // loads at any byte of a word see that word; misaligned stores are
  // filtered out before this decode is acted on.
  function automatic mmio_reg_e mmio_decode(input logic [7:0] offset);
    mmio_reg_e sel;
    case ({offset[7:2], 2'b00})
      CPU6_MMIO_MTIME_LO:    sel = MMIO_MTIME_LO;
      CPU6_MMIO_MTIME_HI:    sel = MMIO_MTIME_HI;
      CPU6_MMIO_MTIMECMP_LO: sel = MMIO_MTIMECMP_LO;
      CPU6_MMIO_MTIMECMP_HI: sel = MMIO_MTIMECMP_HI;
      CPU6_MMIO_TXDATA:      sel = MMIO_TXDATA;
      CPU6_MMIO_STATUS:      sel = MMIO_STATUS;
      default:               sel = MMIO_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/cpu6_txfifo.sv
// Console TX FIFO: circular buffer with wrap-bit pointers.
// Ports:
//   clk, reset (async active-low)
//   push/din  : write din when not full (push while full is ignored)
//   pop       : remove head when not empty
//   dout      : head entry, forced to 0 while empty
//   full/empty/count : occupancy, all derived from the registered pointers
module cpu6_txfifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  // The extra pointer bit tells full (same index, different lap) from empty.
  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]) && (wr_ptr_r[AW] != rd_ptr_r[AW]);
  assign count     = wr_ptr_r - rd_ptr_r;
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign dout      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

  // Pointer state; reset empties the FIFO and discards pending entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

  // Entry storage; contents are don't-care until written, dout is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= din;
    end
  end

endmodule

// File: rtl/cpu6_dmem_responder.sv
// Responder end of the cpu6 core data-memory port.
// Serves a word RAM and an MMIO window holding a 64-bit mtime/mtimecmp timer
// and a console TX FIFO. Loads are combinational so the core MEM stage gets
// data in the same cycle.
// Ports:
//   clk, reset (async active-low)
//   memwriteM/dataaddr/writedata : store strobe, byte address, store data
//   readdata  : load data, combinational from dataaddr
//   tx_valid/tx_data/tx_ready    : TX FIFO head handshake
//   timer_irq : registered mtime >= mtimecmp
//   misalign  : one-cycle pulse the cycle after a misaligned store
module cpu6_dmem_responder
  import cpu6_dmem_responder_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
  parameter int          TXQ_DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            memwriteM,
  input  logic [XLEN-1:0] dataaddr,
  input  logic [XLEN-1:0] writedata,
  output logic [XLEN-1:0] readdata,
  output logic            tx_valid,
  output logic [7:0]      tx_data,
  input  logic            tx_ready,
  output logic            timer_irq,
  output logic            misalign
);

  localparam int IDX_W = $clog2(RAM_WORDS);
  localparam int CNT_W = $clog2(TXQ_DEPTH) + 1;

  logic              is_mmio_s;
  logic              aligned_s;
  logic              store_ok_s;
  mmio_reg_e         reg_sel_s;
  logic [IDX_W-1:0]  ram_idx_s;
  logic [XLEN-1:0]   ram_r [RAM_WORDS];

  logic [63:0]       mtime_r;
  logic [63:0]       mtimecmp_r;
  logic              timer_irq_r;
  logic              misalign_r;
  logic              overflow_r;

  logic              wr_ram_s;
  logic              wr_mtime_lo_s;
  logic              wr_mtime_hi_s;
  logic              wr_cmp_lo_s;
  logic              wr_cmp_hi_s;
  logic              wr_txdata_s;
  logic              wr_status_s;
  logic              ovf_set_s;
  logic              ovf_clr_s;

  logic              fifo_pop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic [7:0]        fifo_dout_s;
  logic              unused_addr_s;

  // Upper RAM address bits alias by design and are intentionally not decoded.
  assign unused_addr_s = ^dataaddr;

  assign is_mmio_s  = (dataaddr[CPU6_MMIO_SEL_HIGH:CPU6_MMIO_SEL_LOW] ==
                       MMIO_BASE[CPU6_MMIO_SEL_HIGH:CPU6_MMIO_SEL_LOW]);
  assign aligned_s  = (dataaddr[1:0] == 2'b00);
  assign store_ok_s = memwriteM & aligned_s;
  assign reg_sel_s  = mmio_decode(dataaddr[7:0]);
  assign ram_idx_s  = dataaddr[IDX_W+1:2];

  // Store decode: one write enable per target, only for aligned stores.
  always_comb begin
    wr_ram_s      = 1'b0;
    wr_mtime_lo_s = 1'b0;
    wr_mtime_hi_s = 1'b0;
    wr_cmp_lo_s   = 1'b0;
    wr_cmp_hi_s   = 1'b0;
    wr_txdata_s   = 1'b0;
    wr_status_s   = 1'b0;
    if (store_ok_s) begin
      if (is_mmio_s) begin
        case (reg_sel_s)
          MMIO_MTIME_LO:    wr_mtime_lo_s = 1'b1;
          MMIO_MTIME_HI:    wr_mtime_hi_s = 1'b1;
          MMIO_MTIMECMP_LO: wr_cmp_lo_s   = 1'b1;
          MMIO_MTIMECMP_HI: wr_cmp_hi_s   = 1'b1;
          MMIO_TXDATA:      wr_txdata_s   = 1'b1;
          MMIO_STATUS:      wr_status_s   = 1'b1;
          default:          wr_ram_s      = 1'b0;
        endcase
      end else begin
        wr_ram_s = 1'b1;
      end
    end else begin
      wr_ram_s = 1'b0;
    end
  end

  // Full is sampled before any same-cycle pop, so push+pop on a full FIFO drops the push.
  assign ovf_set_s  = wr_txdata_s & fifo_full_s;
  assign ovf_clr_s  = wr_status_s & writedata[STATUS_CLR_OVF_BIT];
  assign fifo_pop_s = tx_ready & ~fifo_empty_s;

  cpu6_txfifo #(
    .DEPTH (TXQ_DEPTH),
    .WIDTH (8)
  ) u_txfifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txdata_s),
    .pop   (fifo_pop_s),
    .din   (writedata[7:0]),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Word RAM; not reset, whole-word writes only.
  always_ff @(posedge clk) begin
    if (wr_ram_s) begin
      ram_r[ram_idx_s] <= writedata;
    end
  end

  // Timer: a write to either mtime half replaces that half and skips the increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mtime_r     <= 64'd0;
      mtimecmp_r  <= 64'hFFFF_FFFF_FFFF_FFFF;
      timer_irq_r <= 1'b0;
    end else begin
      if (wr_mtime_lo_s) begin
        mtime_r[31:0] <= writedata[31:0];
      end else if (wr_mtime_hi_s) begin
        mtime_r[63:32] <= writedata[31:0];
      end else begin
        mtime_r <= mtime_r + 64'd1;
      end
      if (wr_cmp_lo_s) begin
        mtimecmp_r[31:0] <= writedata[31:0];
      end
      if (wr_cmp_hi_s) begin
        mtimecmp_r[63:32] <= writedata[31:0];
      end
      timer_irq_r <= (mtime_r >= mtimecmp_r);
    end
  end

  // Misalign pulse and sticky overflow; a same-cycle set beats the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      misalign_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      misalign_r <= memwriteM & ~aligned_s;
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr_s) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Load mux: RAM or MMIO register, unmapped MMIO offsets read zero.
  always_comb begin
    readdata = {XLEN{1'b0}};
    if (is_mmio_s) begin
      case (reg_sel_s)
        MMIO_MTIME_LO:    readdata[31:0] = mtime_r[31:0];
        MMIO_MTIME_HI:    readdata[31:0] = mtime_r[63:32];
        MMIO_MTIMECMP_LO: readdata[31:0] = mtimecmp_r[31:0];
        MMIO_MTIMECMP_HI: readdata[31:0] = mtimecmp_r[63:32];
        MMIO_TXDATA: begin
          readdata[31]          = fifo_full_s;
          readdata[CNT_W-1:0]   = fifo_count_s;
        end
        MMIO_STATUS:      readdata[3:0] = {overflow_r, timer_irq_r, fifo_full_s, fifo_empty_s};
        default:          readdata = {XLEN{1'b0}};
      endcase
    end else begin
      readdata = ram_r[ram_idx_s];
    end
  end

  assign tx_valid  = ~fifo_empty_s;
  assign tx_data   = fifo_dout_s;
  assign timer_irq = timer_irq_r;
  assign misalign  = misalign_r;

endmodule

// File: tb/tb_cpu6_dmem_responder.sv
// Self-checking bench for cpu6_dmem_responder: directed scenarios followed by
// random traffic, all checked against a behavioural model through queues that
// a negedge monitor drains.
module tb_cpu6_dmem_responder;

  localparam int RAM_WORDS = 1024;
  localparam int DEPTH     = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwriteM;
  logic [31:0] dataaddr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        timer_irq;
  logic        misalign;

  always #5 clk = ~clk;

  cpu6_dmem_responder #(
    .XLEN      (32),
    .RAM_WORDS (RAM_WORDS),
    .MMIO_BASE (32'h8000_0000),
    .TXQ_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .memwriteM (memwriteM),
    .dataaddr  (dataaddr),
    .writedata (writedata),
    .readdata  (readdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .timer_irq (timer_irq),
    .misalign  (misalign)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [31:0] m_ram [int];
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  logic        m_irq;
  logic        m_mis;
  logic        m_ovf;
  logic [7:0]  m_fifo [$];

  // Scoreboard queues
  typedef struct packed { logic [31:0] addr; logic [31:0] exp; } rd_exp_t;
  typedef struct packed { logic irq; logic mis; logic tv; } st_exp_t;
  rd_exp_t    rd_q [$];
  st_exp_t    st_q [$];
  logic [7:0] tx_q [$];
  logic       rd_chk = 1'b0;
  logic       st_chk = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
    logic [31:0] r;
    int idx;
    known = 1'b1;
    r = 32'd0;
    if (a[31:28] == 4'h8) begin
      case ({a[7:2], 2'b00})
        8'h00:   r = m_mtime[31:0];
        8'h04:   r = m_mtime[63:32];
        8'h08:   r = m_cmp[31:0];
        8'h0C:   r = m_cmp[63:32];
        8'h10:   r = {(m_fifo.size() == DEPTH), 27'd0, 4'(m_fifo.size())};
        8'h14:   r = {28'd0, m_ovf, m_irq, (m_fifo.size() == DEPTH), (m_fifo.size() == 0)};
        default: r = 32'd0;
      endcase
    end else begin
      idx = int'((a >> 2) % RAM_WORDS);
      if (m_ram.exists(idx)) r = m_ram[idx];
      else known = 1'b0;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_mtime = 64'd0;
    m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    m_irq   = 1'b0;
    m_mis   = 1'b0;
    m_ovf   = 1'b0;
    m_fifo.delete();
    tx_q.delete();
    rd_q.delete();
    st_q.delete();
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    logic [63:0] t_old;
    logic [63:0] c_old;
    bit full_pre, st, mm, loaded, push, ovf_set, ovf_clr;
    t_old    = m_mtime;
    c_old    = m_cmp;
    full_pre = (m_fifo.size() == DEPTH);
    st       = memwriteM && (dataaddr[1:0] == 2'b00);
    mm       = (dataaddr[31:28] == 4'h8);
    loaded   = 1'b0;
    push     = 1'b0;
    ovf_set  = 1'b0;
    ovf_clr  = 1'b0;
    if (tx_ready && m_fifo.size() > 0) void'(m_fifo.pop_front());
    if (st && !mm) m_ram[int'((dataaddr >> 2) % RAM_WORDS)] = writedata;
    if (st && mm) begin
      case ({dataaddr[7:2], 2'b00})
        8'h00: begin m_mtime[31:0]  = writedata; loaded = 1'b1; end
        8'h04: begin m_mtime[63:32] = writedata; loaded = 1'b1; end
        8'h08: m_cmp[31:0]  = writedata;
        8'h0C: m_cmp[63:32] = writedata;
        8'h10: if (full_pre) ovf_set = 1'b1; else push = 1'b1;
        8'h14: ovf_clr = writedata[3];
        default: ;
      endcase
    end
    if (!loaded) m_mtime = t_old + 64'd1;
    if (push) begin
      m_fifo.push_back(writedata[7:0]);
      tx_q.push_back(writedata[7:0]);
    end
    if (ovf_clr) m_ovf = 1'b0;
    if (ovf_set) m_ovf = 1'b1;
    m_irq = (t_old >= c_old);
    m_mis = memwriteM && (dataaddr[1:0] != 2'b00);
  endtask

  // One bus cycle: drive at posedge+1, queue expectations, advance the model at the edge.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic rdy, input bit chk_rd);
    bit known;
    logic [31:0] e;
    st_exp_t s;
    memwriteM = we;
    dataaddr  = a;
    writedata = wd;
    tx_ready  = rdy;
    e = model_read(a, known);
    rd_chk = chk_rd && known;
    if (rd_chk) rd_q.push_back('{addr: a, exp: e});
    s.irq = m_irq;
    s.mis = m_mis;
    s.tv  = (m_fifo.size() != 0);
    st_q.push_back(s);
    st_chk = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Monitor: compares DUT outputs against queued expectations at every negedge.
  always @(negedge clk) begin
    rd_exp_t r;
    st_exp_t s;
    logic [7:0] b;
    if (rd_chk) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL readdata_queue_empty got=%h", readdata);
      end else begin
        r = rd_q.pop_front();
        if (readdata !== r.exp) begin
          errors++;
          $display("FAIL readdata addr=%h got=%h exp=%h", r.addr, readdata, r.exp);
        end
      end
    end
    if (st_chk && st_q.size() > 0) begin
      s = st_q.pop_front();
      checks += 3;
      if (timer_irq !== s.irq) begin
        errors++;
        $display("FAIL timer_irq got=%b exp=%b", timer_irq, s.irq);
      end
      if (misalign !== s.mis) begin
        errors++;
        $display("FAIL misalign got=%b exp=%b", misalign, s.mis);
      end
      if (tx_valid !== s.tv) begin
        errors++;
        $display("FAIL tx_valid got=%b exp=%b", tx_valid, s.tv);
      end
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_unexpected got=%h", tx_data);
      end else begin
        b = tx_q.pop_front();
        if (tx_data !== b) begin
          errors++;
          $display("FAIL tx_data got=%h exp=%h", tx_data, b);
        end
      end
    end
  end

  initial begin
    reset     = 1'b0;
    memwriteM = 1'b0;
    dataaddr  = 32'd0;
    writedata = 32'd0;
    tx_ready  = 1'b0;
    model_reset();
    #1;
    check("reset_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("reset_tx_data", {56'd0, tx_data}, 64'd0);
    check("reset_irq", {63'd0, timer_irq}, 64'd0);
    check("reset_misalign", {63'd0, misalign}, 64'd0);
    repeat (3) @(posedge clk);
    release_reset();

    // RAM store/load, alias, old word during store
    step(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 1'b1);
    step(1'b0, 32'h0000_0040, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'h0000_0040 + RAM_WORDS * 4, 32'd0, 1'b0, 1'b1);
    step(1'b1, 32'h0000_0040, 32'h1234_5678, 1'b0, 1'b1);
    step(1'b0, 32'h0000_0040, 32'd0, 1'b0, 1'b1);

    // Misaligned store dropped, one-cycle flag
    step(1'b1, 32'h0000_0042, 32'hCAFE_F00D, 1'b0, 1'b1);
    step(1'b0, 32'h0000_0040, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'h0000_0041, 32'd0, 1'b0, 1'b1);

    // Timer compare at 20
    step(1'b1, 32'h8000_000C, 32'd0, 1'b0, 1'b1);
    step(1'b1, 32'h8000_0008, 32'd20, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b0, (i % 2 == 0) ? 32'h8000_0000 : 32'h8000_0014, 32'd0, 1'b0, 1'b1);

    // mtime 64-bit wrap
    step(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1);
    step(1'b1, 32'h8000_0004, 32'hFFFF_FFFF, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, (i % 2 == 0) ? 32'h8000_0000 : 32'h8000_0004, 32'd0, 1'b0, 1'b1);

    // FIFO overflow, drain, overflow clear
    for (int i = 0; i < 5; i++) step(1'b1, 32'h8000_0010, 32'h41 + i, 1'b0, 1'b1);
    step(1'b0, 32'h8000_0014, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'h8000_0010, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h8000_0014, 32'd0, 1'b1, 1'b1);
    step(1'b1, 32'h8000_0014, 32'h8, 1'b0, 1'b1);
    step(1'b0, 32'h8000_0014, 32'd0, 1'b0, 1'b1);

    // Full FIFO push+pop, then reset mid-drain
    for (int i = 0; i < 4; i++) step(1'b1, 32'h8000_0010, 32'h60 + i, 1'b0, 1'b1);
    step(1'b1, 32'h8000_0010, 32'h99, 1'b1, 1'b1);
    step(1'b0, 32'h8000_0010, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'h8000_0014, 32'd0, 1'b1, 1'b1);
    rd_chk    = 1'b0;
    st_chk    = 1'b0;
    memwriteM = 1'b0;
    dataaddr  = 32'h8000_0000;
    reset     = 1'b0;
    model_reset();
    #1;
    check("midreset_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("midreset_mtime_lo", {32'd0, readdata}, 64'd0);
    check("midreset_irq", {63'd0, timer_irq}, 64'd0);
    release_reset();
    step(1'b0, 32'h8000_0014, 32'd0, 1'b0, 1'b1);
    step(1'b0, 32'h8000_000C, 32'd0, 1'b0, 1'b1);

    // Random traffic over a pre-initialised RAM window and the MMIO window
    for (int i = 0; i < 16; i++) step(1'b1, 32'h0000_0040 + i * 4, $urandom, 1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic        we;
      a = $urandom;
      if ($urandom_range(0, 1) == 0) begin
        a[31:28] = 4'h8;
        a[7:0]   = 8'($urandom_range(0, 7) * 4);
      end else begin
        if (a[31:28] == 4'h8) a[31:28] = 4'h3;
        a[11:2] = 10'(16 + $urandom_range(0, 15));
      end
      if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
      else a[1:0] = 2'b00;
      we = ($urandom_range(0, 2) == 0);
      step(we, a, $urandom, 1'($urandom_range(0, 1)), 1'b1);
    end

    // Final drain: every byte the model accepted must have come out
    for (int i = 0; i < 6; i++) step(1'b0, 32'h8000_0014, 32'd0, 1'b1, 1'b1);
    check("tx_all_drained", 64'(tx_q.size()), 64'd0);
    check("final_tx_valid", {63'd0, tx_valid}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
